fpu_operand_loader: RTL and testbench

Byte-serial front/back end for the FPU adder under test. Assembles two 32-bit IEEE 754 operands from a UART-style byte stream and drives them to the adder's `a`/`b` inputs. After a fixed settle time, captures the adder's combinational result and streams it back out as four bytes over a valid/ready handshake. Sits between the board UART RX/TX blocks and the combinational adder in the FPU test design.

---
 rtl/fpu_operand_loader.sv | 193 +++++++++++++++++++
 tb/tb_fpu_operand_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : fpu_operand_loader
// Description : Byte-serial loader for a combinational FPU adder. Assembles
//               two 32-bit operands from an 8-byte frame, waits a settle
//               time, then streams the 32-bit result back out as 4 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_operand_loader #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] fpu_result,
    output logic [31:0] result_q,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_err
);

    localparam int c_idle_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_idle_w-1:0]   c_idle_last   = c_idle_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RECV   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TX     = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [2:0]            r_byte_cnt;
    logic [55:0]           r_shift;      // first 7 bytes; the 8th comes straight from rx_data
    logic [c_idle_w-1:0]   r_idle;
    logic [c_settle_w-1:0] r_settle;
    logic [1:0]            r_tx_idx;

    logic                  w_accept;
    logic                  w_frame_done;
    logic                  w_timeout;
    logic                  w_settle_done;
    logic                  w_tx_xfer;
    logic                  w_tx_last;
    logic [7:0]            w_next_byte;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RECV;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_frame_done  = 1'b0;
        w_timeout     = 1'b0;
        w_settle_done = 1'b0;
        w_tx_xfer     = 1'b0;
        w_tx_last     = 1'b0;
        case (r_state)
            ST_RECV: begin
                if (rx_valid) begin
                    // A byte arriving on the limit cycle wins over the timeout
                    w_accept = 1'b1;
                    if (r_byte_cnt == 3'd7) begin
                        w_frame_done = 1'b1;
                        w_state_next = ST_SETTLE;
                    end
                end else if ((r_byte_cnt != 3'd0) && (r_idle == c_idle_last)) begin
                    w_timeout = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_settle == c_settle_last) begin
                    w_settle_done = 1'b1;
                    w_state_next  = ST_TX;
                end
            end
            ST_TX: begin
                if (tx_valid && tx_ready) begin
                    w_tx_xfer = 1'b1;
                    if (r_tx_idx == 2'd3) begin
                        w_tx_last    = 1'b1;
                        w_state_next = ST_RECV;
                    end
                end
            end
            default: begin
                w_state_next = ST_RECV;
            end
        endcase
    end

    always_comb begin
        w_next_byte = result_q[31:24];
        case (r_tx_idx)
            2'd0:    w_next_byte = result_q[23:16];
            2'd1:    w_next_byte = result_q[15:8];
            2'd2:    w_next_byte = result_q[7:0];
            default: w_next_byte = result_q[31:24];
        endcase
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= 3'd0;
            r_shift    <= 56'd0;
            r_idle     <= '0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= w_timeout;

            if (w_frame_done) begin
                r_byte_cnt <= 3'd0;
                r_shift    <= 56'd0;
                op_a       <= r_shift[55:24];
                op_b       <= {r_shift[23:0], rx_data};
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
                r_shift    <= {r_shift[47:0], rx_data};
            end else if (w_timeout) begin
                r_byte_cnt <= 3'd0;
                r_shift    <= 56'd0;
            end

            if (w_accept || w_timeout || (r_byte_cnt == 3'd0) || (r_state != ST_RECV)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Settle, capture and transmit path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_tx_idx <= 2'd0;
            result_q <= 32'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy <= (w_state_next != ST_RECV);

            if (w_frame_done) begin
                r_settle <= '0;
            end else if (r_state == ST_SETTLE) begin
                r_settle <= r_settle + 1'b1;
            end

            if (w_settle_done) begin
                result_q <= fpu_result;
                tx_data  <= fpu_result[31:24];
                tx_valid <= 1'b1;
                r_tx_idx <= 2'd0;
            end else if (w_tx_last) begin
                tx_valid <= 1'b0;
            end else if (w_tx_xfer) begin
                tx_data  <= w_next_byte;
                r_tx_idx <= r_tx_idx + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_operand_loader
// Description : Scoreboard bench for fpu_operand_loader with a stand-in adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_operand_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] fpu_result;
    logic [31:0] result_q;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;
    logic [7:0] exp_q[$];

    localparam logic [63:0] FRAME_BASIC = 64'h40000000_3F800000;
    localparam logic [63:0] FRAME_ALT   = 64'hA1B2C3D4_01020304;

    // Stand-in adder: 2.0 - 1.0 for the basic vector, XOR otherwise
    assign fpu_result = (op_a == 32'h40000000 && op_b == 32'h3F800000) ? 32'h3F800000
                                                                         : (op_a ^ op_b);

    fpu_operand_loader #(
        .SETTLE_CYCLES (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .fpu_result(fpu_result),
        .result_q  (result_q),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted tx byte is compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got %h, required no transfer", tx_data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %h, required %h", tx_data, e);
                end
            end
        end
        if (rst_n && frame_err) err_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_result(input logic [31:0] r);
        exp_q.push_back(r[31:24]);
        exp_q.push_back(r[23:16]);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
    endtask

    // Called at posedge+1; returns at E0+1 where E0 accepts the 8th byte
    task automatic send_frame(input logic [63:0] f);
        for (int i = 0; i < 8; i++) begin
            rx_data  = f[63-8*i -: 8];
            rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((busy || tx_valid) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (busy || tx_valid) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b tx_valid=%b after %0d cycles, required idle", busy, tx_valid, n);
        end
    endtask

    task automatic wait_tx_valid(input int max_cycles);
        int n = 0;
        while (!tx_valid && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check("tx_valid_rise", {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic run_basic();
        push_result(32'h3F800000);
        send_frame(FRAME_BASIC);
        check("basic_op_a", op_a, 32'h40000000);
        check("basic_op_b", op_b, 32'h3F800000);
        check("basic_busy_e0", {31'd0, busy}, 32'd1);
        check("basic_txv_e0", {31'd0, tx_valid}, 32'd0);
        @(posedge clk); #1;
        check("basic_txv_e1", {31'd0, tx_valid}, 32'd0);
        @(posedge clk); #1;
        check("basic_txv_e2", {31'd0, tx_valid}, 32'd1);
        check("basic_txd_e2", {24'd0, tx_data}, 32'h3F);
        check("basic_result_q", result_q, 32'h3F800000);
        repeat (4) begin @(posedge clk); #1; end
        check("basic_txv_done", {31'd0, tx_valid}, 32'd0);
        check("basic_busy_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int errs0;
        rst_n    = 1'b0;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_result_q", result_q, 32'd0);
        check("rst_tx", {22'd0, tx_data, tx_valid, busy, frame_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame
        run_basic();

        // Backpressure: tx_data held while tx_ready low
        tx_ready = 1'b0;
        push_result(32'h3F800000);
        send_frame(FRAME_BASIC);
        wait_tx_valid(10);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", {24'd0, tx_data}, 32'h3F);
            check("bp_hold_valid", {31'd0, tx_valid}, 32'd1);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_idle(20);
        check("bp_drained", exp_q.size(), 32'd0);

        // Timeout after 3 bytes, 16 idle cycles
        errs0 = err_pulses;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (15) @(posedge clk);
        #1;
        check("to_err_before", {31'd0, frame_err}, 32'd0);
        @(posedge clk); #1;
        check("to_err_pulse", {31'd0, frame_err}, 32'd1);
        @(posedge clk); #1;
        check("to_err_after", {31'd0, frame_err}, 32'd0);
        check("to_err_count", err_pulses - errs0, 32'd1);
        check("to_op_a_kept", op_a, 32'h40000000);
        run_basic();

        // Timeout boundary: second byte on the 16th idle cycle is accepted
        errs0 = err_pulses;
        push_result(32'h1D3B5977);
        send_byte(8'h12);
        repeat (15) @(posedge clk);
        #1;
        send_byte(8'h34);
        send_frame({48'h5678_0F0F_0F0F, 16'h0000} ) ;
        check("tb_err_none", err_pulses - errs0, 32'd0);
        check("tb_op_a", op_a, 32'h12345678);
        check("tb_op_b", op_b, 32'h0F0F0F0F);
        wait_idle(20);
        check("tb_result_q", result_q, 32'h1D3B5977);

        // Ninth byte arrives in SETTLE and must be dropped
        push_result(32'h3F800000);
        send_frame(FRAME_BASIC);
        send_byte(8'hAA);
        wait_idle(20);
        push_result(32'hA0B0C0D0);
        send_frame(FRAME_ALT);
        check("drop_op_a", op_a, 32'hA1B2C3D4);
        check("drop_op_b", op_b, 32'h01020304);
        wait_idle(20);
        check("drop_result_q", result_q, 32'hA0B0C0D0);

        // Reset after two bytes have transferred
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h80);
        send_frame(FRAME_BASIC);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_op_a", op_a, 32'd0);
        check("mrst_op_b", op_b, 32'd0);
        check("mrst_result_q", result_q, 32'd0);
        check("mrst_tx", {22'd0, tx_data, tx_valid, busy, frame_err}, 32'd0);
        check("mrst_sent", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_basic();

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // The 6 trailing bytes of the boundary frame are carried in the top of a 64-bit word
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
